pipelined_rotate_left_shifter: RTL and testbench
================================================

PIPELINED_ROTATE_LEFT_SHIFTER -- requirements
Module: pipelined_rotate_left_shifter

Interface
- REQ-001: Parameter DATA_WIDTH, default 32; data width in bits; SHALL be a power of two, >= 2.
- REQ-002: Derived constant SHAMT_W = clog2(DATA_WIDTH); shift-amount width and pipeline depth.
- REQ-003: CLK input 1; single clock, all state on rising edge.
- REQ-004: RSTN input 1; asynchronous, active-low reset.
- REQ-005: IDATA input DATA_WIDTH; operand to rotate.
- REQ-006: ISHAMT input SHAMT_W; rotate-left amount, 0..DATA_WIDTH-1.
- REQ-007: IVALID input 1; IDATA/ISHAMT valid this cycle.
- REQ-008: IREADY output 1; stage 0 can accept this cycle.
- REQ-009: ODATA output DATA_WIDTH; rotated result.
- REQ-010: OVALID output 1; ODATA valid this cycle.
- REQ-011: OREADY input 1; downstream accepts ODATA this cycle.

Function
- REQ-012: ODATA SHALL equal IDATA rotated left by ISHAMT: bits shifted out of the MSB re-enter at the LSB; ISHAMT=0 passes IDATA unchanged.
- REQ-013: SHAMT_W registered stages; stage k rotates left by 2^k when amount bit k is 1, else passes; remaining amount bits travel with the data.
- REQ-014: Latency SHALL be exactly SHAMT_W cycles from input acceptance to OVALID with no back-pressure (5 cycles at DATA_WIDTH=32).
- REQ-015: Input transfer occurs when IVALID && IREADY; output transfer occurs when OVALID && OREADY.
- REQ-016: Each stage k holds valid bit V[k]; stage k SHALL load when V[k]=0 or stage k+1 loads (last stage: when OREADY=1).
- REQ-017: IREADY SHALL equal the stage-0 load condition; it is combinational from OREADY through the ready chain.
- REQ-018: Throughput SHALL be one transfer per cycle while OREADY=1.
- REQ-019: Bubbles SHALL collapse: with OREADY=0, an upstream stage with V=0 SHALL still accept from its predecessor.
- REQ-020: While OVALID=1 and OREADY=0, ODATA SHALL remain stable.
- REQ-021: A simultaneous input and output transfer in the same cycle, with a full pipeline, SHALL lose no item and duplicate no item.
- REQ-022: Items SHALL leave in acceptance order.

Reset
- REQ-023: RSTN low SHALL immediately clear all V[k] (OVALID=0) and all data and amount registers to 0, independent of CLK.
- REQ-024: Reset asserted mid-operation SHALL discard every in-flight item; none appears after release.
- REQ-025: First acceptance is possible on the first rising edge after RSTN deasserts; IREADY=1 while the pipeline is empty.

Configuration
- REQ-026: Macro ROTATE_LEFT_DIR_SEL_EN, when defined, adds input IDIR (1 bit; 0=left, 1=right).
- REQ-027: With IDIR=1 the effective amount SHALL be (DATA_WIDTH - ISHAMT) mod DATA_WIDTH, computed combinationally before stage 0; latency is unchanged.
- REQ-028: Without the macro, IDIR SHALL not exist and every operation SHALL be a rotate-left.

Structure
- REQ-029: The shared barrel-shifter package SHALL hold the SHAMT_W calculation (clog2 function) and the direction encoding constants ROT_LEFT=0 and ROT_RIGHT=1.
- REQ-030: One sub-module, rotate_left_stage, SHALL implement one combinational stage (parameters DATA_WIDTH and N, inputs IDATA and SHIFT, output ODATA), instantiated SHAMT_W times with N=2^k.

Verification
- REQ-031: IDATA=0x80000001, ISHAMT=1, OREADY=1 -> ODATA=0x00000003 exactly 5 cycles later.
- REQ-032: Stream of 0x12345678 with ISHAMT=0..31 on consecutive cycles, OREADY=1 -> 32 consecutive outputs, the last being 0x091A2B3C, no gaps.
- REQ-033: Fill the pipeline, then hold OREADY=0 for 10 cycles -> IREADY=0 once 5 items are held, ODATA stable; on release, all items arrive in order.
- REQ-034: Random OREADY toggling with 1000 random operands -> scoreboard matches the reference rotate; no loss or duplication.
- REQ-035: RSTN pulsed low with 3 items in flight -> OVALID=0 immediately; no stale output after release.
- REQ-036 (ROTATE_LEFT_DIR_SEL_EN): IDIR=1, IDATA=0x00000001, ISHAMT=1 -> ODATA=0x80000000; ISHAMT=0 -> 0x00000001.

Source files
------------

// File: rtl/pipelined_rotate_left_shifter_pkg.sv
// Shared constants and helpers for the pipelined barrel rotator.
// Holds the shift-amount width calculation and the rotate direction encoding.
package pipelined_rotate_left_shifter_pkg;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rotate_left_stage.sv
// One combinational barrel stage: rotates left by N bit positions when SHIFT is set,
// otherwise passes IDATA through unchanged.
module rotate_left_stage
  import pipelined_rotate_left_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 1
) (
  input  logic [DATA_WIDTH-1:0] IDATA,
  input  logic                  SHIFT,
  output logic [DATA_WIDTH-1:0] ODATA
);

  assign ODATA = SHIFT ? {IDATA[DATA_WIDTH-N-1:0], IDATA[DATA_WIDTH-1:DATA_WIDTH-N]} : IDATA;

endmodule

// File: rtl/pipelined_rotate_left_shifter.sv
// Pipelined rotate-left barrel shifter with a valid/ready handshake and collapsing bubbles.
// Define ROTATE_LEFT_DIR_SEL_EN to add the IDIR input (0 = left, 1 = right).
module pipelined_rotate_left_shifter
  import pipelined_rotate_left_shifter_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 32,
  localparam int unsigned SHAMT_W    = clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] IDATA,
  input  logic [SHAMT_W-1:0]    ISHAMT,
  input  logic                  IVALID,
`ifdef ROTATE_LEFT_DIR_SEL_EN
  input  logic                  IDIR,
`endif
  output logic                  IREADY,
  output logic [DATA_WIDTH-1:0] ODATA,
  output logic                  OVALID,
  input  logic                  OREADY
);

  // Register k holds the operand before rotation k; the rotation sits on its output.
  // The amount is shifted right each stage so every stage consumes bit 0.
  logic [DATA_WIDTH-1:0] data_q  [SHAMT_W];
  logic [DATA_WIDTH-1:0] data_d  [SHAMT_W];
  logic [SHAMT_W-1:0]    amt_q   [SHAMT_W];
  logic [SHAMT_W-1:0]    amt_d   [SHAMT_W];
  logic [DATA_WIDTH-1:0] rot_out [SHAMT_W];
  logic [SHAMT_W-1:0]    valid_q;
  logic [SHAMT_W-1:0]    valid_d;
  logic [SHAMT_W:0]      load;
  logic [SHAMT_W-1:0]    shamt_eff;

`ifdef ROTATE_LEFT_DIR_SEL_EN
  // A right rotate by s equals a left rotate by (DATA_WIDTH - s) mod DATA_WIDTH.
  assign shamt_eff = (IDIR == ROT_RIGHT) ? ('0 - ISHAMT) : ISHAMT;
`else
  assign shamt_eff = ISHAMT;
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    rotate_left_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .N         (1 << k)
    ) u_stage (
      .IDATA(data_q[k]),
      .SHIFT(amt_q[k][0]),
      .ODATA(rot_out[k])
    );
  end

  always_comb begin
    load          = '0;
    load[SHAMT_W] = OREADY;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    if (load[0]) begin
      valid_d[0] = IVALID;
      data_d[0]  = IDATA;
      amt_d[0]   = shamt_eff;
    end
    for (int k = 1; k < SHAMT_W; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = rot_out[k-1];
        amt_d[k]   = amt_q[k-1] >> 1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      amt_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

  assign IREADY = load[0];
  assign OVALID = valid_q[SHAMT_W-1];
  assign ODATA  = rot_out[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_rotate_left_shifter.sv
// Randomized self-checking bench for pipelined_rotate_left_shifter (DATA_WIDTH = 32).
// Honours ROTATE_LEFT_DIR_SEL_EN by connecting and exercising IDIR.
module tb_pipelined_rotate_left_shifter;

  localparam int DEPTH = 5;

  logic        CLK;
  logic        RSTN;
  logic [31:0] IDATA;
  logic [4:0]  ISHAMT;
  logic        IVALID;
  logic        IREADY;
  logic [31:0] ODATA;
  logic        OVALID;
  logic        OREADY;
`ifdef ROTATE_LEFT_DIR_SEL_EN
  logic        IDIR;
`endif

  int          n_checks;
  int          n_fails;
  int          acc_cnt;
  logic [31:0] exp_q[$];

  pipelined_rotate_left_shifter #(
    .DATA_WIDTH(32)
  ) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .IDATA (IDATA),
    .ISHAMT(ISHAMT),
    .IVALID(IVALID),
`ifdef ROTATE_LEFT_DIR_SEL_EN
    .IDIR  (IDIR),
`endif
    .IREADY(IREADY),
    .ODATA (ODATA),
    .OVALID(OVALID),
    .OREADY(OREADY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the 64-bit doubled word shifted left leaves the rotation in its upper half.
  function automatic logic [31:0] rotate_ref(input logic [31:0] x, input logic [4:0] s,
                                             input logic dir);
    logic [63:0] w;
    int          amt;
    amt = dir ? (32 - int'(s)) % 32 : int'(s);
    w   = {x, x} << amt;
    return w[63:32];
  endfunction

  // Scoreboard: on every cycle, compare against the queue of accepted, not yet delivered items.
  initial begin : monitor
    logic        hold;
    logic [31:0] hold_data;
    logic        cur_dir;
    hold      = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge CLK);
      cur_dir = 1'b0;
`ifdef ROTATE_LEFT_DIR_SEL_EN
      cur_dir = IDIR;
`endif
      if (!RSTN) begin
        exp_q.delete();
        hold = 1'b0;
        check("reset_ovalid", 32'(OVALID), 32'd0);
      end else begin
        if (hold) begin
          check("hold_ovalid", 32'(OVALID), 32'd1);
          check("hold_odata", ODATA, hold_data);
        end
        check("iready", 32'(IREADY), 32'(OREADY || (exp_q.size() < DEPTH)));
        if (exp_q.size() == 0) begin
          check("empty_ovalid", 32'(OVALID), 32'd0);
        end else if (OVALID && OREADY) begin
          check("odata", ODATA, exp_q.pop_front());
        end
        if (IVALID && IREADY) begin
          exp_q.push_back(rotate_ref(IDATA, ISHAMT, cur_dir));
          acc_cnt++;
        end
        hold      = OVALID && !OREADY;
        hold_data = ODATA;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    int          lat;
    int          gaps;
    int          n;
    int          target;
    logic [31:0] last;
    n_checks = 0;
    n_fails  = 0;
    acc_cnt  = 0;
    RSTN     = 1'b0;
    IDATA    = '0;
    ISHAMT   = '0;
    IVALID   = 1'b0;
    OREADY   = 1'b1;
`ifdef ROTATE_LEFT_DIR_SEL_EN
    IDIR     = 1'b0;
`endif

    // Pin the model itself with hand-computed values.
    check("model_rotl1", rotate_ref(32'h8000_0001, 5'd1, 1'b0), 32'h0000_0003);
    check("model_rotl31", rotate_ref(32'h1234_5678, 5'd31, 1'b0), 32'h091A_2B3C);
    check("model_rotr1", rotate_ref(32'h0000_0001, 5'd1, 1'b1), 32'h8000_0000);

    #2;
    check("rst_ovalid", 32'(OVALID), 32'd0);
    check("rst_iready", 32'(IREADY), 32'd1);
    check("rst_odata", ODATA, 32'd0);
    repeat (2) @(posedge CLK);
    #3 RSTN = 1'b1;

    // Single item: latency and value.
    tick();
    IDATA  = 32'h8000_0001;
    ISHAMT = 5'd1;
    IVALID = 1'b1;
    @(negedge CLK);
    check("first_accept", 32'(IREADY), 32'd1);
    tick();
    IVALID = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!OVALID && lat < 20);
    check("latency", lat, 32'd5);
    check("single_odata", ODATA, 32'h0000_0003);
    wait_drain("single_drain");

    // Back-to-back stream of every shift amount.
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          tick();
          IDATA  = 32'h1234_5678;
          ISHAMT = 5'(i);
          IVALID = 1'b1;
        end
        tick();
        IVALID = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!OVALID && n < 40);
        check("stream_start", ODATA, 32'h1234_5678);
        gaps = 0;
        last = ODATA;
        for (int i = 1; i < 32; i++) begin
          @(negedge CLK);
          if (!OVALID) gaps++;
          last = ODATA;
        end
        check("stream_gaps", gaps, 32'd0);
        check("stream_last", last, 32'h091A_2B3C);
      end
    join
    wait_drain("stream_drain");

    // Stall: fill the pipeline against OREADY=0, then release.
    tick();
    OREADY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      IDATA  = $urandom();
      ISHAMT = 5'($urandom_range(0, 31));
      IVALID = 1'b1;
      tick();
    end
    IVALID = 1'b0;
    @(negedge CLK);
    check("stall_iready", 32'(IREADY), 32'd0);
    check("stall_ovalid", 32'(OVALID), 32'd1);
    check("stall_count", 32'(exp_q.size()), 32'(DEPTH));
    tick();
    OREADY = 1'b1;
    wait_drain("stall_drain");

    // Random traffic with random back-pressure.
    target = acc_cnt + 1000;
    n = 0;
    while (acc_cnt < target && n < 20000) begin
      tick();
      IDATA  = $urandom();
      ISHAMT = 5'($urandom_range(0, 31));
      IVALID = ($urandom_range(0, 3) != 0);
      OREADY = ($urandom_range(0, 1) != 0);
`ifdef ROTATE_LEFT_DIR_SEL_EN
      IDIR   = ($urandom_range(0, 1) != 0);
`endif
      n++;
    end
    check("random_accepted", 32'(acc_cnt >= target), 32'd1);
    tick();
    IVALID = 1'b0;
    OREADY = 1'b1;
`ifdef ROTATE_LEFT_DIR_SEL_EN
    IDIR   = 1'b0;
`endif
    wait_drain("random_drain");

    // Asynchronous reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      tick();
      IDATA  = 32'hA5A5_0000 + 32'(i);
      ISHAMT = 5'(i + 3);
      IVALID = 1'b1;
    end
    tick();
    IVALID = 1'b0;
    @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("midrst_ovalid", 32'(OVALID), 32'd0);
    check("midrst_iready", 32'(IREADY), 32'd1);
    repeat (2) @(posedge CLK);
    #3 RSTN = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (OVALID) n++;
    end
    check("midrst_stale", n, 32'd0);

`ifdef ROTATE_LEFT_DIR_SEL_EN
    // Right rotation via IDIR.
    tick();
    IDIR   = 1'b1;
    IDATA  = 32'h0000_0001;
    ISHAMT = 5'd1;
    IVALID = 1'b1;
    tick();
    ISHAMT = 5'd0;
    tick();
    IVALID = 1'b0;
    IDIR   = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!OVALID && n < 20);
    check("dir_right1", ODATA, 32'h8000_0000);
    @(negedge CLK);
    check("dir_right0", ODATA, 32'h0000_0001);
    wait_drain("dir_drain");
`endif

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
